division_unit: RTL and testbench
================================

Name: division_unit

Overview:
Sequential unsigned integer divider for the ALU, one quotient bit per clock (restoring algorithm).
- Accepts dividend A and divisor B on a start pulse.
- After WIDTH cycles, presents quotient Res and remainder with a one-cycle done pulse.
- Sits beside the multiplier in the ALU datapath; the ALU control sequencer drives start and waits on done.

Parameters:
- WIDTH, 16, operand and quotient width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only when not busy.
- A  input  WIDTH  unsigned dividend.
- B  input  WIDTH  unsigned divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Res/remainder become valid.
- Res  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH+1  unsigned remainder, zero-extended; bit WIDTH is always 0 on a valid result.
- div_by_zero  output  1  set with done when B was 0; held until next accepted start.

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, done=0, Res=0, remainder=0, div_by_zero=0, counter=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Capture A and B into internal registers.
  - Clear partial remainder (WIDTH+1 bits) and counter.
  - Clear div_by_zero.
  - Go to RUN, or to DONE directly if B==0.
- RUN, each cycle:
  - Shift partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract B (WIDTH+1-bit arithmetic). If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - Increment counter. After WIDTH iterations, load Res/remainder, pulse done, go to DONE.
- Latency and handshake:
  - With start sampled at edge E0, busy=1 after E0 through edge E_WIDTH.
  - done=1 for exactly the cycle after E_WIDTH (WIDTH cycles of latency).
- DONE: outputs hold their values; done deasserts after one cycle; returns to IDLE if no start. A start in the done cycle is accepted (back-to-back operations).
- start while busy: ignored; A/B changes during RUN have no effect (operands are latched).
- Outputs hold the last result until the next completion or reset; they do not track inputs combinationally.
- Divide by zero (B==0):
  - One-cycle latency: done pulses in the cycle after the start edge.
  - Res = all ones, remainder = {0, A}, div_by_zero=1.
- Reset mid-operation: aborts immediately, all outputs return to reset values, and no done is produced.
- Arithmetic: unsigned only, no overflow possible; Res*B + remainder == A for B!=0, with remainder < B.

Decomposition:
- Package division_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Default WIDTH constant.
  - Counter width localparam: $clog2(WIDTH+1).
- One sub-module is natural: division_step.
  - Combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - The top module contains the FSM, operand registers, counter and output registers.

Test Plan:
- Reset asserted mid-RUN (start A=798,B=11, assert rst after 5 cycles) -> busy=0, done never pulses, Res=0, remainder=0; after release, a fresh start completes normally.
- Directed set, each started from IDLE:
  - 798/11 -> Res=72, remainder=6.
  - 200/40 -> 5 r0.
  - 90/9 -> 10 r0.
  - 70/10 -> 7 r0.
  - 16/3 -> 5 r1.
  - 255/5 -> 51 r0.
  - For each: done exactly 16 cycles after the start edge, busy high 16 cycles.
- Divide by zero: A=0,B=0 -> done after 1 cycle, Res=16'hFFFF, remainder=0, div_by_zero=1. A=1234,B=0 -> remainder=1234.
- Extremes:
  - 65535/1 -> 65535 r0.
  - 1/65535 -> 0 r1.
  - 65535/65535 -> 1 r0.
  - 0/7 -> 0 r0.
- Handshake:
  - start pulsed again during RUN with different A/B -> ignored; result matches the first operands.
  - start in the done cycle (16/3 then 90/9) -> second result 10 r0 exactly 16 cycles later.
- Hold: after completion, change A/B with no start for 20 cycles -> Res/remainder unchanged, done stays 0.

Source files
------------

// File: rtl/division_pkg.sv
// division_pkg: shared types and constants for the sequential restoring divider.
// Contents: FSM state enum, default operand width, counter-width helper.
package division_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_WIDTH = 16;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
    localparam int CNT_W = cnt_width(DEF_WIDTH);
endpackage

// File: rtl/division_unit_if.sv
// division_unit_if: request/result bundle between the ALU sequencer and the divider.
// Signals: start, A (dividend), B (divisor) from master; busy, done, Res (quotient),
// remainder (WIDTH+1 bits, zero-extended), div_by_zero from slave.
interface division_unit_if
    import division_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Res;
    logic [WIDTH:0]   remainder;
    logic             div_by_zero;
    modport master (output start, A, B, input busy, done, Res, remainder, div_by_zero);
    modport slave  (input start, A, B, output busy, done, Res, remainder, div_by_zero);
endinterface

// File: rtl/division_step.sv
// division_step: one combinational restoring-division iteration.
// Ports: prem (partial remainder in), bit_in (next dividend MSB), divisor,
// rem_out (partial remainder out), q (quotient bit).
module division_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   prem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    // One extra bit so the trial difference carries a clean sign bit.
    assign shifted = {prem, bit_in};
    assign diff    = shifted - {2'b00, divisor};
    assign q       = ~diff[WIDTH+1];
    assign rem_out = q ? diff[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/division_unit.sv
// division_unit: sequential unsigned divider, one quotient bit per clock.
// Ports: clk, rst (async active-high), bus (division_unit_if slave: start/A/B in,
// busy/done/Res/remainder/div_by_zero out).
module division_unit
    import division_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    division_unit_if.slave        bus
);
    localparam int CW = cnt_width(WIDTH);
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dv;
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   nrem;
    logic             qb;
    // dq holds the dividend; quotient bits shift in from the LSB as dividend bits leave the MSB.
    division_step #(.WIDTH(WIDTH)) u_step (
        .prem    (prem),
        .bit_in  (dq[WIDTH-1]),
        .divisor (dv),
        .rem_out (nrem),
        .q       (qb)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            dq              <= '0;
            dv              <= '0;
            prem            <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.Res         <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                RUN: begin
                    prem <= nrem;
                    dq   <= {dq[WIDTH-2:0], qb};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state         <= DONE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.Res       <= {dq[WIDTH-2:0], qb};
                        bus.remainder <= nrem;
                    end
                end
                default: begin
                    if (bus.start) begin
                        dq   <= bus.A;
                        dv   <= bus.B;
                        prem <= '0;
                        cnt  <= '0;
                        if (bus.B == '0) begin
                            // Zero divisor short-circuits to a saturated quotient next cycle.
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.Res         <= '1;
                            bus.remainder   <= {1'b0, bus.A};
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state           <= RUN;
                            bus.busy        <= 1'b1;
                            bus.div_by_zero <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_division_unit.sv
// tb_division_unit: directed scoreboard bench for division_unit (WIDTH=16).
module tb_division_unit;
    localparam int W = 16;
    typedef struct {
        logic [W-1:0] q;
        logic [W:0]   r;
        logic         z;
        int           lat;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int lat;
    int busy_cnt;
    logic [W-1:0] last_q;
    logic [W:0]   last_r;
    division_unit_if #(.WIDTH(W)) bus ();
    division_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    // Drives start across one edge (E0); caller positions time before the edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.q   = (b == 0) ? '1 : a / b;
        e.r   = (b == 0) ? {1'b0, a} : {1'b0, a % b};
        e.z   = (b == 0);
        e.lat = (b == 0) ? 0 : W;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        busy_cnt = 0;
    endtask
    // Waits (bounded) for done; optionally re-pulses start with junk operands at cycle pulse_at.
    task automatic wait_done(input string tag, input int pulse_at);
        exp_t e;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            bus.start = (lat == pulse_at);
            if (lat == pulse_at) begin
                bus.A = 16'd1;
                bus.B = 16'd1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
        end
        if (!bus.done) begin
            chk({tag, "_timeout"}, 32'(lat), 32'd40 + 32'd1);
        end else if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
            chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
            chk({tag, "_res"}, 32'(bus.Res), 32'(e.q));
            chk({tag, "_rem"}, 32'(bus.remainder), 32'(e.r));
            chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(e.z));
            last_q = e.q;
            last_r = e.r;
        end
    endtask
    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        launch(a, b);
        wait_done(tag, -1);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_res", 32'(bus.Res), 0);
        chk("rst_rem", 32'(bus.remainder), 0);
        chk("rst_dbz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        op("d798_11", 16'd798, 16'd11);
        chk("d798_11_q_const", 32'(bus.Res), 72);
        chk("d798_11_r_const", 32'(bus.remainder), 6);
        op("d200_40", 16'd200, 16'd40);
        op("d90_9", 16'd90, 16'd9);
        op("d70_10", 16'd70, 16'd10);
        op("d16_3", 16'd16, 16'd3);
        chk("d16_3_q_const", 32'(bus.Res), 5);
        chk("d16_3_r_const", 32'(bus.remainder), 1);
        op("d255_5", 16'd255, 16'd5);
        op("z0_0", 16'd0, 16'd0);
        chk("z0_0_q_const", 32'(bus.Res), 32'hFFFF);
        op("z1234_0", 16'd1234, 16'd0);
        chk("z1234_r_const", 32'(bus.remainder), 1234);
        op("d65535_1", 16'hFFFF, 16'd1);
        op("d1_65535", 16'd1, 16'hFFFF);
        op("d65535_65535", 16'hFFFF, 16'hFFFF);
        op("d0_7", 16'd0, 16'd7);
        chk("dbz_cleared", 32'(bus.div_by_zero), 0);
        for (int i = 0; i < 4; i++) begin
            op("rand", 16'($urandom), 16'($urandom_range(1, 300)));
        end
        // Start pulsed mid-RUN with different operands must be ignored.
        @(negedge clk);
        launch(16'd798, 16'd11);
        wait_done("ignore_start", 3);
        // Back-to-back: second start issued in the done cycle.
        @(negedge clk);
        launch(16'd16, 16'd3);
        wait_done("b2b_first", -1);
        launch(16'd90, 16'd9);
        wait_done("b2b_second", -1);
        chk("b2b_q_const", 32'(bus.Res), 10);
        // Hold: operands move without start, outputs must not.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.A = 16'($urandom);
            bus.B = 16'($urandom);
            @(posedge clk);
            #1;
            chk("hold_done", 32'(bus.done), 0);
            chk("hold_res", 32'(bus.Res), 32'(last_q));
            chk("hold_rem", 32'(bus.remainder), 32'(last_r));
        end
        // Reset mid-RUN aborts without a done pulse.
        @(negedge clk);
        launch(16'd798, 16'd11);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("abort_busy_before", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_res", 32'(bus.Res), 0);
        chk("abort_rem", 32'(bus.remainder), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'(bus.done), 0);
        end
        op("after_abort", 16'd798, 16'd11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
